// File: rtl/soc_sim_harness_ctrl.sv
// rtl/soc_sim_harness_ctrl.sv - SOC simulation harness: core reset sequencing, MMIO store decode, console FIFO
//
// soc_sim_harness_con_fifo : console byte queue with drop indication
// soc_sim_harness_ctrl     : harness controller top
//   CLK, RESET                    clock, synchronous active-high reset
//   core_rst_n                    active-low reset to the core (high only while running)
//   mem_wstrb/addr/wdata/wmask    store port observed from the core
//   gpio_out                      byte-merged GPIO latch
//   console_valid/char/ready      console byte stream out of the FIFO
//   con_overflow                  sticky: a console byte was dropped
//   cycle_count                   saturating count of running cycles
//   done/pass/fail/timeout        run outcome, fail_code = failing signature >> 1

module soc_sim_harness_con_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_ready,
  output logic       valid,
  output logic [7:0] head,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        accept;

  // Extra pointer bit: equal indices with differing wrap bits means full.
  assign valid  = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = valid & pop_ready;
  // A pop in the same cycle frees the head slot, so a full queue can still take a byte.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign head   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module soc_sim_harness_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                RESET_CYCLES = 16,
  parameter int                CNT_W        = 32,
  parameter int                TIMEOUT      = 1000000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0040_0100,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h0040_0008,
  parameter logic [ADDR_W-1:0] GPIO_ADDR    = 32'h0040_0004,
  parameter int                CON_DEPTH    = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic                core_rst_n,
  input  logic                mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   gpio_out,
  output logic                console_valid,
  output logic [7:0]          console_char,
  input  logic                console_ready,
  output logic                con_overflow,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [DATA_W-2:0]   fail_code
);
  localparam int               NB        = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      HOLD_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [DATA_W-1:0] SIG_PASS = 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [31:0]       hold_cnt;
  logic              running;
  logic              st_tohost;
  logic              tohost_hit;
  logic              timeout_hit;
  logic              st_gpio;
  logic              con_push;
  logic              con_drop;
  logic [DATA_W-1:0] gpio_next;

  // Stores only matter while the core is out of reset and the run is live.
  assign running     = (state == S_RUN);
  assign st_tohost   = running && mem_wstrb && (mem_addr == TOHOST_ADDR);
  // Even signatures and partial-width writes to tohost are not decisions.
  assign tohost_hit  = st_tohost && (&mem_wmask) && mem_wdata[0];
  assign timeout_hit = (TIMEOUT != 0) && running && (cycle_count == TMO_LAST);
  assign st_gpio     = running && mem_wstrb && (mem_addr == GPIO_ADDR);
  assign con_push    = running && mem_wstrb && (mem_addr == CONSOLE_ADDR) && mem_wmask[0];

  always_comb begin
    gpio_next = gpio_out;
    for (int i = 0; i < NB; i++) begin
      if (mem_wmask[i]) gpio_next[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  soc_sim_harness_con_fifo #(
    .DEPTH(CON_DEPTH)
  ) u_con_fifo (
    .clk      (CLK),
    .reset    (RESET),
    .push     (con_push),
    .push_data(mem_wdata[7:0]),
    .pop_ready(console_ready),
    .valid    (console_valid),
    .head     (console_char),
    .drop     (con_drop)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_HOLD;
      hold_cnt     <= '0;
      core_rst_n   <= 1'b0;
      cycle_count  <= '0;
      gpio_out     <= '0;
      con_overflow <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_code    <= '0;
    end else begin
      if (con_drop) con_overflow <= 1'b1;
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            core_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        S_RUN: begin
          if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
          if (st_gpio) gpio_out <= gpio_next;
          // A tohost decision in the timeout cycle takes precedence.
          if (tohost_hit) begin
            state      <= S_DONE;
            core_rst_n <= 1'b0;
            done       <= 1'b1;
            if (mem_wdata == SIG_PASS) begin
              pass <= 1'b1;
            end else begin
              fail      <= 1'b1;
              fail_code <= mem_wdata[DATA_W-1:1];
            end
          end else if (timeout_hit) begin
            state      <= S_DONE;
            core_rst_n <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end
        end
        default: begin
          // Terminal: core frozen, status held until RESET.
        end
      endcase
    end
  end
endmodule
